// File: rtl/link_emu.sv
// link_emu: serial-link emulator.
// A source memory is serialised back-to-back, passed through a configurable
// delay line, deserialised on a frame marker, captured and compared.
module link_emu #(
  parameter int unsigned N         = 8,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned AW        = 4,
  parameter int unsigned LINK_DLY  = 0,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cont,
  input  logic          stop,
  input  logic          inj_err,
  input  logic          src_we,
  input  logic [AW-1:0] src_addr,
  input  logic [N-1:0]  src_din,
  input  logic [AW-1:0] cap_addr,
  output logic [N-1:0]  cap_dout,
  output logic          ser_out,
  output logic          frame,
  output logic          busy,
  output logic          done,
  output logic          rx_valid,
  output logic [N-1:0]  rx_data,
  output logic [AW-1:0] rx_addr,
  output logic [15:0]   err_cnt
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  // Words in flight never exceed (N+LINK_DLY)/N + 2, so 5 bits is ample.
  localparam int unsigned FW = 5;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREFETCH = 2'd1;
  localparam logic [1:0] S_SHIFT    = 2'd2;

  logic [N-1:0]  src_mem [DEPTH];
  logic [N-1:0]  cap_mem [DEPTH];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          cont_q;
  logic          stop_seen;
  logic [AW-1:0] tx_addr;
  logic [AW-1:0] tx_addr_nxt_c;
  logic [CW-1:0] tx_bit;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_shift_c;
  logic [N-1:0]  nxt_word;
  logic          start_ok_c;
  logic          word_end_c;
  logic          last_word_c;
  logic          load_c;

  logic          tx_fin;
  logic [FW-1:0] inflight;

  logic          line_in_c;
  logic          lnk_bit;
  logic          lnk_frame;

  logic [CW-1:0] rx_cnt;
  logic [N-2:0]  rx_acc;
  logic [N-1:0]  rx_word_c;
  logic [N-2:0]  rx_acc_nxt_c;

  // Control decodes shared by the FSM and datapath
  always_comb begin
    start_ok_c    = (state == S_IDLE) && start && !busy;
    word_end_c    = (tx_bit == CW'(N - 1));
    last_word_c   = cont_q ? (stop_seen || stop) : (tx_addr == AW'(DEPTH - 1));
    load_c        = (state == S_PREFETCH) ||
                    ((state == S_SHIFT) && word_end_c && !last_word_c);
    tx_addr_nxt_c = (tx_addr == AW'(DEPTH - 1)) ? '0 : tx_addr + 1'b1;
    sreg_shift_c  = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
  end

  // Serial bit at the transmitter is the outgoing end of the shift register
  assign ser_out = LSB_FIRST ? sreg[0] : sreg[N-1];

  // Source memory write port, locked out during a run
  always_ff @(posedge clk) begin
    if (src_we && !busy && (32'(src_addr) < DEPTH)) begin
      src_mem[src_addr] <= src_din;
    end
  end

  // Capture memory write port, fed by each received word
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      cap_mem[rx_addr] <= rx_data;
    end
  end

  // Capture readback register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dout <= '0;
    end else begin
      cap_dout <= (32'(cap_addr) < DEPTH) ? cap_mem[cap_addr] : '0;
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // TX FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_ok_c) state_nxt = S_PREFETCH;
      S_PREFETCH: state_nxt = S_SHIFT;
      S_SHIFT:    if (word_end_c && last_word_c) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // TX datapath: word fetch, gapless reload and bit shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q    <= 1'b0;
      stop_seen <= 1'b0;
      tx_addr   <= '0;
      tx_bit    <= '0;
      sreg      <= '0;
      nxt_word  <= '0;
      frame     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          frame <= 1'b0;
          if (start_ok_c) begin
            cont_q    <= cont;
            stop_seen <= 1'b0;
            tx_addr   <= '0;
            tx_bit    <= '0;
          end
        end
        S_PREFETCH: begin
          sreg   <= src_mem[0];
          frame  <= 1'b1;
          tx_bit <= '0;
          if (cont_q && stop) stop_seen <= 1'b1;
        end
        S_SHIFT: begin
          if (cont_q && stop) stop_seen <= 1'b1;
          // Fetch one bit early so the reload below needs no extra cycle
          if (tx_bit == CW'(N - 2)) nxt_word <= src_mem[tx_addr_nxt_c];
          if (word_end_c) begin
            tx_bit <= '0;
            if (last_word_c) begin
              sreg  <= '0;
              frame <= 1'b0;
            end else begin
              sreg    <= nxt_word;
              frame   <= 1'b1;
              tx_addr <= tx_addr_nxt_c;
            end
          end else begin
            tx_bit <= tx_bit + 1'b1;
            sreg   <= sreg_shift_c;
            frame  <= 1'b0;
          end
        end
        default: begin
          sreg  <= '0;
          frame <= 1'b0;
        end
      endcase
    end
  end

  // Run control: busy/done follow the last word TX sent through RX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_fin   <= 1'b0;
      inflight <= '0;
    end else begin
      done <= 1'b0;
      if (start_ok_c) begin
        busy     <= 1'b1;
        tx_fin   <= 1'b0;
        inflight <= '0;
      end else if (busy) begin
        if ((state == S_SHIFT) && word_end_c && last_word_c) tx_fin <= 1'b1;
        inflight <= inflight + FW'(load_c) - FW'(rx_valid);
        if (tx_fin && rx_valid && (inflight == FW'(1))) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign line_in_c = ser_out ^ inj_err;

  // Link delay: data and frame marker travel through matching register chains
  generate
    if (LINK_DLY == 0) begin : g_nodly
      assign lnk_bit   = line_in_c;
      assign lnk_frame = frame;
    end else begin : g_dly
      logic [LINK_DLY-1:0] bit_q;
      logic [LINK_DLY-1:0] frm_q;

      // Delay-line shift registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bit_q <= '0;
          frm_q <= '0;
        end else begin
          bit_q[0] <= line_in_c;
          frm_q[0] <= frame;
          for (int unsigned i = 1; i < LINK_DLY; i++) begin
            bit_q[i] <= bit_q[i-1];
            frm_q[i] <= frm_q[i-1];
          end
        end
      end

      assign lnk_bit   = bit_q[LINK_DLY-1];
      assign lnk_frame = frm_q[LINK_DLY-1];
    end
  endgenerate

  // Word assembly in original bit order, including the bit arriving now
  always_comb begin
    rx_word_c    = LSB_FIRST ? {lnk_bit, rx_acc} : {rx_acc, lnk_bit};
    rx_acc_nxt_c = LSB_FIRST ? rx_word_c[N-1:1] : rx_word_c[N-2:0];
  end

  // RX: frame-aligned bit counter, word delivery, capture address and compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_acc   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_addr  <= '0;
      err_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_acc   <= rx_acc_nxt_c;
      if (start_ok_c) begin
        rx_cnt  <= '0;
        rx_addr <= '0;
        err_cnt <= '0;
      end else begin
        if (rx_valid) begin
          rx_addr <= (rx_addr == AW'(DEPTH - 1)) ? '0 : rx_addr + 1'b1;
          if ((rx_data != src_mem[rx_addr]) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        if (lnk_frame) begin
          rx_cnt <= CW'(1);
        end else if (rx_cnt == CW'(N - 1)) begin
          rx_cnt   <= '0;
          rx_valid <= 1'b1;
          rx_data  <= rx_word_c;
        end else if (rx_cnt != '0) begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_link_emu.sv
// tb_link_emu: two link_emu instances (LSB-first no delay, MSB-first delay 3)
// driven in parallel and checked cycle by cycle against a timing model.
module tb_link_emu;

  localparam int N     = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int MAXW  = 64;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cont;
  logic          stop;
  logic          inj_err;
  logic          src_we;
  logic [AW-1:0] src_addr;
  logic [N-1:0]  src_din;
  logic [AW-1:0] cap_addr;

  logic [1:0][N-1:0]  cap_o;
  logic [1:0]         ser_o;
  logic [1:0]         frm_o;
  logic [1:0]         busy_o;
  logic [1:0]         done_o;
  logic [1:0]         rxv_o;
  logic [1:0][N-1:0]  rxd_o;
  logic [1:0][AW-1:0] rxa_o;
  logic [1:0][15:0]   err_o;

  logic [N-1:0] src_m [DEPTH];
  logic [N-1:0] cap_m [2][DEPTH];
  bit           cap_ok [2][DEPTH];

  int n_tests;
  int n_fail;

  link_emu #(.N(N), .DEPTH(DEPTH), .AW(AW), .LINK_DLY(0), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .inj_err(inj_err), .src_we(src_we), .src_addr(src_addr), .src_din(src_din),
    .cap_addr(cap_addr), .cap_dout(cap_o[0]), .ser_out(ser_o[0]), .frame(frm_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .rx_valid(rxv_o[0]), .rx_data(rxd_o[0]),
    .rx_addr(rxa_o[0]), .err_cnt(err_o[0])
  );

  link_emu #(.N(N), .DEPTH(DEPTH), .AW(AW), .LINK_DLY(3), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .inj_err(inj_err), .src_we(src_we), .src_addr(src_addr), .src_din(src_din),
    .cap_addr(cap_addr), .cap_dout(cap_o[1]), .ser_out(ser_o[1]), .frame(frm_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .rx_valid(rxv_o[1]), .rx_data(rxd_o[1]),
    .rx_addr(rxa_o[1]), .err_cnt(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dly(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit lsbf(input int d);
    return (d == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string when);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s ser_out d%0d", when, d), 32'(ser_o[d]), 32'd0);
      check($sformatf("%s frame d%0d", when, d), 32'(frm_o[d]), 32'd0);
      check($sformatf("%s busy d%0d", when, d), 32'(busy_o[d]), 32'd0);
      check($sformatf("%s done d%0d", when, d), 32'(done_o[d]), 32'd0);
      check($sformatf("%s rx_valid d%0d", when, d), 32'(rxv_o[d]), 32'd0);
      check($sformatf("%s rx_data d%0d", when, d), 32'(rxd_o[d]), 32'd0);
      check($sformatf("%s rx_addr d%0d", when, d), 32'(rxa_o[d]), 32'd0);
      check($sformatf("%s err_cnt d%0d", when, d), 32'(err_o[d]), 32'd0);
      check($sformatf("%s cap_dout d%0d", when, d), 32'(cap_o[d]), 32'd0);
    end
  endtask

  task automatic load_src(input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      src_we   = 1'b1;
      src_addr = AW'(i);
      src_din  = rnd ? N'($urandom) : ((i == DEPTH - 1) ? 8'h9A : N'(8'h11 * (i + 1)));
      src_m[i] = src_din;
    end
    @(negedge clk);
    src_we = 1'b0;
  endtask

  // One run: stop_cyc / inj cycles / poke_cyc / rst_cyc are relative to the
  // start cycle (0); a value of 0 means "not used".
  task automatic do_run(input bit c, input int stop_cyc, input int inj0, input int inj1,
                        input int poke_cyc, input int rst_cyc);
    int nw, t_end, ecnt, k, b, kv, bi;
    int dcyc [2];
    int rxc [2][MAXW];
    int inj [2];
    logic [N-1:0] xw [2][MAXW];
    logic [N-1:0] w;
    logic e_ser, e_frm, e_vld;

    nw = c ? ((stop_cyc - 2) / N + 1) : DEPTH;
    inj[0] = inj0;
    inj[1] = inj1;
    for (int d = 0; d < 2; d++) begin
      dcyc[d] = (nw - 1) * N + N + 3 + dly(d);
      for (int kk = 0; kk < nw; kk++) begin
        rxc[d][kk] = kk * N + N + 2 + dly(d);
        xw[d][kk]  = src_m[kk % DEPTH];
      end
      for (int j = 0; j < 2; j++) begin
        if (inj[j] >= 2 && (inj[j] - 2) / N < nw) begin
          k  = (inj[j] - 2) / N;
          b  = (inj[j] - 2) % N;
          bi = lsbf(d) ? b : (N - 1 - b);
          xw[d][k][bi] = ~xw[d][k][bi];
        end
      end
    end
    t_end = (rst_cyc > 0) ? rst_cyc : dcyc[1] + 2;

    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(posedge clk);
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      start   = 1'b0;
      cont    = 1'b0;
      src_we  = 1'b0;
      stop    = 1'b0;
      inj_err = 1'b0;
      for (int d = 0; d < 2; d++) begin
        e_ser = 1'b0;
        e_frm = 1'b0;
        if (t >= 2 && (t - 2) / N < nw) begin
          k = (t - 2) / N;
          b = (t - 2) % N;
          w = src_m[k % DEPTH];
          e_ser = lsbf(d) ? w[b] : w[N - 1 - b];
          e_frm = (b == 0);
        end
        e_vld = 1'b0;
        kv    = 0;
        ecnt  = 0;
        for (int kk = 0; kk < nw; kk++) begin
          if (rxc[d][kk] == t) begin
            e_vld = 1'b1;
            kv    = kk;
          end
          if (rxc[d][kk] < t && xw[d][kk] != src_m[kk % DEPTH]) ecnt++;
        end
        check($sformatf("ser_out d%0d t%0d", d, t), 32'(ser_o[d]), 32'(e_ser));
        check($sformatf("frame d%0d t%0d", d, t), 32'(frm_o[d]), 32'(e_frm));
        check($sformatf("busy d%0d t%0d", d, t), 32'(busy_o[d]), 32'(t < dcyc[d]));
        check($sformatf("done d%0d t%0d", d, t), 32'(done_o[d]), 32'(t == dcyc[d]));
        check($sformatf("rx_valid d%0d t%0d", d, t), 32'(rxv_o[d]), 32'(e_vld));
        check($sformatf("err_cnt d%0d t%0d", d, t), 32'(err_o[d]), 32'(ecnt));
        if (e_vld) begin
          check($sformatf("rx_data d%0d w%0d", d, kv), 32'(rxd_o[d]), 32'(xw[d][kv]));
          check($sformatf("rx_addr d%0d w%0d", d, kv), 32'(rxa_o[d]), 32'(kv % DEPTH));
        end
      end
      if (t == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check_zero("midrun reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        inj_err = (t == inj0) || (t == inj1);
        stop    = (t == stop_cyc);
        if (t == poke_cyc) begin
          start    = 1'b1;
          src_we   = 1'b1;
          src_addr = AW'(2);
          src_din  = ~src_m[2];
        end
      end
    end
    @(negedge clk);
    start   = 1'b0;
    cont    = 1'b0;
    src_we  = 1'b0;
    stop    = 1'b0;
    inj_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int kk = 0; kk < nw; kk++) begin
        if (rst_cyc == 0 || rxc[d][kk] < rst_cyc) begin
          cap_m[d][kk % DEPTH]  = xw[d][kk];
          cap_ok[d][kk % DEPTH] = 1'b1;
        end
      end
    end
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      cap_addr = AW'(i);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cap_ok[d][i]) begin
          check($sformatf("capture d%0d a%0d", d, i), 32'(cap_o[d]), 32'(cap_m[d][i]));
        end
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cont     = 1'b0;
    stop     = 1'b0;
    inj_err  = 1'b0;
    src_we   = 1'b0;
    src_addr = '0;
    src_din  = '0;
    cap_addr = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) cap_ok[d][i] = 1'b0;
    end
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed pattern, single pass
    load_src(1'b0);
    do_run(1'b0, 0, 0, 0, 0, 0);
    readback();

    // Injected errors on bit 2 of words 1 and 4, with start/src_we poked while busy
    do_run(1'b0, 0, 2 + 1 * N + 2, 2 + 4 * N + 2, 20, 0);
    readback();

    // Continuous mode, stop during word 3 of the third pass
    load_src(1'b1);
    do_run(1'b1, 2 + (2 * DEPTH + 3) * N + int'($urandom_range(0, N - 1)), 0, 0, 0, 0);
    readback();

    // Continuous mode, random stop word and random injections
    load_src(1'b1);
    do_run(1'b1, 2 + int'($urandom_range(0, 25)) * N + int'($urandom_range(0, N - 1)),
           int'($urandom_range(2, 60)), int'($urandom_range(61, 200)), 0, 0);
    readback();

    // Reset mid-word 5, then a clean rerun with random injections
    load_src(1'b1);
    do_run(1'b0, 0, 0, 0, 0, 2 + 5 * N + 3);
    do_run(1'b0, 0, int'($urandom_range(2, 40)), int'($urandom_range(41, 81)), 0, 0);
    readback();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/link_emu.md
# link_emu

Parametrised serial-link emulator: a loadable source memory is serialised with no idle cycle between words, passed through a configurable-delay link, deserialised using a frame marker and written into a capture memory. Each received word is checked against the source, and mismatches are counted. It replaces the fixed 8-bit, wasted-cycle shift-register/BRAM test path as the GBT-link stand-in for the DTC tester, and is observed through the ChipScope VIO/ILA.

## Interface
- N, 8, word width in bits (≥2)
- DEPTH, 10, words per pass (2..2^AW)
- AW, 4, address width
- LINK_DLY, 0, extra register stages on the serial line (0..15)
- LSB_FIRST, 1, 1: data[0] sent first; 0: data[N-1] sent first

- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only while idle
- cont  in  1  sampled with start; 1 selects continuous (wrapping) mode
- stop  in  1  end a continuous run at the next word boundary
- inj_err  in  1  invert the serial bit entering the link this cycle
- src_we  in  1  source memory write; ignored while busy
- src_addr  in  AW  source write address
- src_din  in  N  source write data
- cap_addr  in  AW  capture readback address
- cap_dout  out  N  capture readback data, registered
- ser_out  out  1  serial bit at the transmitter, before the link delay
- frame  out  1  high while ser_out carries the first bit of a word
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at the end of a run
- rx_valid  out  1  one-cycle pulse when a received word is complete
- rx_data  out  N  received word, valid with rx_valid
- rx_addr  out  AW  capture address of rx_data
- err_cnt  out  16  count of mismatched words, saturating

## Operation
- Memories:
  - Source and capture are DEPTH×N register arrays with synchronous write.
  - Source has two read ports: one for TX, one for the RX compare.
  - Neither memory is cleared by reset.
- TX FSM states: IDLE → PREFETCH → SHIFT → IDLE.
  - IDLE: start=1 moves to PREFETCH and clears err_cnt and all addresses.
  - PREFETCH: reads source word 0.
  - SHIFT: a bit counter runs 0..N-1. At bit N-2 the next word is read, and at bit N-1 the shift register reloads, so there is no gap between words.
- Transmit sequence:
  - Single mode: words 0..DEPTH-1 are sent once, then the TX side returns to IDLE.
  - Continuous mode: the address wraps DEPTH-1 → 0. Once stop is seen, TX finishes the current word and returns to IDLE.
  - stop has no effect in single mode.
- Link: ser_out XOR inj_err passes through LINK_DLY registers. frame passes through an identical delay path.
- RX:
  - The delayed frame marker resets the bit counter.
  - After N bits, rx_valid pulses and rx_data is presented in the original bit order.
  - The word is written to capture[rx_addr]; rx_addr increments and wraps at DEPTH-1.
- Compare: on each rx_valid, if rx_data ≠ source[rx_addr], err_cnt increments. err_cnt saturates at 0xFFFF.
- Run end: the run ends when RX has consumed the last word TX sent. done then pulses and busy falls in the same cycle.
- Ignored inputs: start while busy; src_we while busy.
- Idle outputs: ser_out=0 and frame=0.

## Timing
- Reset values: every output 0, FSM in IDLE, all counters 0, delay-line contents 0. Reset takes effect immediately at any point, including mid-run. Memory contents are retained.
- Cycle numbering: cycle 0 is the cycle in which start is sampled (edge E0).
- Transmitter timing:
  - busy is high from cycle 1.
  - Word k, bit b appears on ser_out in cycle 2+kN+b.
  - frame is high in cycle 2+kN.
- Receiver timing:
  - rx_valid for word k is high in cycle kN+N+2+LINK_DLY.
  - The capture write and the err_cnt update occur at the end of that cycle.
- Single run: done is high in cycle DEPTH·N+3+LINK_DLY, and busy is 0 from that cycle.
- Readback: cap_dout reflects cap_addr one cycle after it is applied. Reading the address being written in the same cycle returns the old data.
- stop asserted during word k (continuous mode): word k is the last word sent; done follows k's rx_valid by 1 cycle.

## Test plan
- N=8, DEPTH=10, LINK_DLY=0, source 0x11..0x9A, single run:
  - ser_out is contiguous for 80 cycles with frame every 8 cycles.
  - rx_valid pulses 10 times, the first in cycle 10.
  - capture equals source, err_cnt=0.
  - done is high in cycle 83.
- Same run with LINK_DLY=3 and LSB_FIRST=0: every rx_valid shifts by 3 cycles, capture is unchanged, MSB is first on ser_out.
- inj_err pulsed on bit 2 of words 1 and 4: err_cnt=2, capture[1]=source[1]^0x04 and capture[4]=source[4]^0x04.
- Continuous mode, stop raised during word 3 of the third pass:
  - rx_addr wraps 9→0 twice.
  - Last rx_valid carries word 3, followed by done.
  - err_cnt=0.
- Reset asserted mid-word 5:
  - All outputs are 0 immediately.
  - A fresh start reruns cleanly, with err_cnt restarting from 0.
- start and src_we pulsed while busy: both are ignored; the source is unchanged and the run timing is unchanged.
